// File: rtl/button_debouncer_if.sv
// Push-button bus between the pads and the lab2 encoder: raw active-low pads in,
// debounced levels, press pulses and an any-pressed flag out.
interface button_debouncer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] buttons_raw;
    logic [WIDTH-1:0] buttons_db;
    logic [WIDTH-1:0] press_pulse;
    logic             any_pressed;

    modport master (
        output buttons_raw,
        input  buttons_db,
        input  press_pulse,
        input  any_pressed
    );

    modport slave (
        input  buttons_raw,
        output buttons_db,
        output press_pulse,
        output any_pressed
    );
endinterface

// File: rtl/button_debouncer.sv
// Per-bit 2-flop synchronizer plus saturating stability counter for active-low buttons.
// Define BUTTON_DEBOUNCER_PULSE_EN to generate registered one-cycle press pulses.
module button_debouncer #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic               clk,
    input  logic               reset_n,
    button_debouncer_if.slave  bus
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    generate
        if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (1 << 24)) begin : g_bad_cycles
            $error("button_debouncer: DEBOUNCE_CYCLES must be within 1 .. 2^24");
        end
    endgenerate

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_next;
    logic [CW-1:0]    cnt [WIDTH];
    logic             any_q;

    // A bit flips only on the cycle its counter has already seen DEBOUNCE_CYCLES-1 mismatches.
    always_comb begin
        db_next = db;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2[i] != db[i] && cnt[i] == CNT_MAX) begin
                db_next[i] = sync2[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '1;
            sync2 <= '1;
            db    <= '1;
            any_q <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= bus.buttons_raw;
            sync2 <= sync1;
            db    <= db_next;
            any_q <= ~&db_next;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == db[i] || cnt[i] == CNT_MAX) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign bus.buttons_db  = db;
    assign bus.any_pressed = any_q;

`ifdef BUTTON_DEBOUNCER_PULSE_EN
    logic [WIDTH-1:0] pulse_q;

    // Press is a released-to-pressed (1->0) change of the debounced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pulse_q <= '0;
        end else begin
            pulse_q <= db & ~db_next;
        end
    end

    assign bus.press_pulse = pulse_q;
`else
    assign bus.press_pulse = '0;
`endif

endmodule

// File: doc/button_debouncer.md
Name: button_debouncer

Overview:
- Front-end conditioning stage for the board push-buttons; sits directly upstream of the lab2 priority encoder / LED mux and drives its 8-bit active-low `buttons` bus.
- Per bit: 2-flop synchronizer, then a saturating stability counter.
- Emits debounced levels (still active-low) plus optional one-cycle press-event pulses.

Parameters:
- WIDTH, 8, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, clock cycles a synchronized level must hold before being accepted (10 ms at 50 MHz). Legal range is 1 to 2^24; elaboration fails outside it.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- buttons_raw  input  WIDTH  raw pad inputs, active-low (0 = pressed), asynchronous to clk.
- buttons_db  output  WIDTH  debounced levels, active-low, registered; feeds the encoder's `buttons`.
- press_pulse  output  WIDTH  one-cycle high per bit on debounced press (1->0 transition).
- any_pressed  output  1  registered OR of inverted buttons_db (high if any debounced bit is 0).

Behaviour:
- Reset, asynchronous on reset_n low:
  - Both synchronizer stages = all ones.
  - buttons_db = all ones (released).
  - All counters = 0.
  - press_pulse = 0.
  - any_pressed = 0.
  - Deassertion of reset is synchronous to clk by board convention; no internal reset synchronizer.
- Synchronizer: sync1 <= buttons_raw, then sync2 <= sync1. Only sync2 is used downstream.
- Per-bit counter, width $clog2(DEBOUNCE_CYCLES), minimum 1 bit. Two states, "stable" (cnt = 0) and "counting" (cnt > 0). Each rising edge, for bit i:
  - sync2[i] == buttons_db[i]: cnt <= 0. A glitch shorter than DEBOUNCE_CYCLES aborts the change, and the count restarts from 0 on the next mismatch.
  - sync2[i] != buttons_db[i] and cnt != DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - sync2[i] != buttons_db[i] and cnt == DEBOUNCE_CYCLES-1: buttons_db[i] <= sync2[i], and cnt <= 0.
- Latency: a raw level held steady from sampling edge E1 appears on buttons_db on edge E(DEBOUNCE_CYCLES+2).
  - Example: DEBOUNCE_CYCLES=4 gives 6 edges.
  - DEBOUNCE_CYCLES=1 gives 3 edges, i.e. synchronizer plus one cycle, with no filtering.
- Bits are fully independent. Simultaneous transitions on several bits each complete on their own schedule; there is no priority between bits.
- any_pressed is registered from the next-state value of buttons_db, so it changes on the same edge as buttons_db.
- Counters never wrap: the compare at DEBOUNCE_CYCLES-1 always fires before overflow.
- Reset mid-count: counters and outputs return immediately to reset values. A button held through reset is re-accepted DEBOUNCE_CYCLES+2 edges after release of reset.

Optional Feature:
- Macro BUTTON_DEBOUNCER_PULSE_EN.
- Defined: press_pulse[i] is registered and high for exactly one cycle, on the same edge where buttons_db[i] goes 1->0. It is never asserted on release (0->1).
- Undefined: press_pulse is tied to all zeros and no pulse registers are generated. The port list is unchanged.

Test Plan:
- Reset values: run with DEBOUNCE_CYCLES=4 and reset_n low for 3 cycles while buttons_raw = 8'h00 → buttons_db = 8'hFF, any_pressed = 0, press_pulse = 8'h00 during reset. After release, buttons_db = 8'h00 on the 6th edge.
- Clean press/release of bit 3: buttons_raw goes 8'hFF→8'hF7 and is held 10 cycles → buttons_db = 8'hF7 exactly 6 edges after the first sampling edge, any_pressed rises on the same edge, press_pulse = 8'h08 for one cycle (PULSE_EN). Releasing to 8'hFF gives 8'hFF after 6 edges with no pulse.
- Glitch rejection: bit 0 low for 3 cycles, high for 1, then low for 3 → buttons_db stays 8'hFF and every counter returns to 0.
- Independent timing: bit 7 pressed at cycle 0 and bit 1 at cycle 2 → buttons_db goes 8'h7F at edge 6 and 8'h7D at edge 8, with press_pulse = 8'h80 then 8'h02.
- Reset mid-count: bit 5 low for 3 cycles, then reset_n pulsed low → buttons_db = 8'hFF immediately. Holding bit 5 low gives 8'hDF 6 edges after reset release.
- Macro off: repeat the clean-press scenario without BUTTON_DEBOUNCER_PULSE_EN → press_pulse stays 8'h00 throughout, and buttons_db timing is identical.
